// File: rtl/gardner_ted_stream.sv
// Streaming Gardner timing-error detector with internal SPS-deep I/Q delay lines,
// a two-stage error pipeline and a block-averaged error output for the loop filter.
module gardner_ted_stream #(
    parameter int WIDTH     = 16,
    parameter int SPS       = 32,
    parameter int MODE      = 0,
    parameter int DIFF_BITS = 8,
    parameter int AVG_LOG2  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] I,
    input  logic signed [WIDTH-1:0] Q,
    input  logic                    sym_strobe,
    input  logic                    flush,
    output logic signed [WIDTH-1:0] error_n,
    output logic                    err_valid,
    output logic signed [WIDTH-1:0] err_avg,
    output logic                    avg_valid
);

    // Handshake: there is no backpressure. A sample is taken on every edge where
    // in_valid=1 and flush=0; err_valid/avg_valid are single-cycle pulses that
    // mark error_n/err_avg as freshly updated, and the values hold otherwise.

    localparam int HALF   = SPS / 2;
    localparam int FILL_W = $clog2(SPS + 1);
    localparam int ACC_W  = WIDTH + AVG_LOG2;
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PROD_W = WIDTH + DIFF_BITS + 1;

    localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(SPS);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'((1 << AVG_LOG2) - 1);
    localparam logic signed [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    // Sign-only Gardner: the mid sample, signed by the direction of the transition.
    function automatic logic signed [WIDTH-1:0] sign_err(
        input logic                    cur_neg,
        input logic                    prev_neg,
        input logic signed [WIDTH-1:0] mid
    );
        logic signed [WIDTH-1:0] r;
        r = '0;
        if (!cur_neg && prev_neg) begin
            r = mid;
        end else if (cur_neg && !prev_neg) begin
            r = (mid == S_MIN) ? S_MAX : -mid;
        end
        return r;
    endfunction

    // Linear Gardner on the top DIFF_BITS of cur/prev, product rescaled and saturated.
    function automatic logic signed [WIDTH-1:0] lin_err(
        input logic [DIFF_BITS-1:0]    cur_m,
        input logic [DIFF_BITS-1:0]    prev_m,
        input logic signed [WIDTH-1:0] mid
    );
        logic signed [DIFF_BITS:0] d;
        logic signed [PROD_W-1:0]  prod;
        logic signed [PROD_W-1:0]  shr;
        logic signed [WIDTH-1:0]   r;
        d    = $signed({cur_m[DIFF_BITS-1], cur_m}) - $signed({prev_m[DIFF_BITS-1], prev_m});
        prod = PROD_W'(mid) * PROD_W'(d);
        shr  = prod >>> (DIFF_BITS - 1);
        if ((&shr[PROD_W-1:WIDTH-1]) || !(|shr[PROD_W-1:WIDTH-1])) begin
            r = shr[WIDTH-1:0];
        end else begin
            r = shr[PROD_W-1] ? S_MIN : S_MAX;
        end
        return r;
    endfunction

    logic signed [WIDTH-1:0] dl_i_q [SPS];
    logic signed [WIDTH-1:0] dl_q_q [SPS];

    logic [FILL_W-1:0]       fill_q, fill_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [WIDTH-1:0] erri_q, erri_d;
    logic signed [WIDTH-1:0] errq_q, errq_d;
    logic signed [WIDTH-1:0] error_n_q, error_n_d;
    logic                    err_valid_q, err_valid_d;
    logic signed [WIDTH-1:0] err_avg_q, err_avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic                    strobe_eff;
    logic signed [WIDTH-1:0] mid_i, mid_q, prev_i, prev_q;
    logic signed [WIDTH-1:0] calc_i, calc_q;
    logic signed [WIDTH-1:0] combined;
    logic signed [ACC_W-1:0] sum;

    assign mid_i  = dl_i_q[HALF-1];
    assign mid_q  = dl_q_q[HALF-1];
    assign prev_i = dl_i_q[SPS-1];
    assign prev_q = dl_q_q[SPS-1];

    generate
        if (MODE == 0) begin : g_sign
            assign calc_i = sign_err(I[WIDTH-1], prev_i[WIDTH-1], mid_i);
            assign calc_q = sign_err(Q[WIDTH-1], prev_q[WIDTH-1], mid_q);
        end else begin : g_lin
            assign calc_i = lin_err(I[WIDTH-1 -: DIFF_BITS], prev_i[WIDTH-1 -: DIFF_BITS], mid_i);
            assign calc_q = lin_err(Q[WIDTH-1 -: DIFF_BITS], prev_q[WIDTH-1 -: DIFF_BITS], mid_q);
        end
    endgenerate

    // flush outranks in_valid: the sample is neither counted nor shifted in.
    assign accept     = in_valid && !flush;
    assign strobe_eff = accept && sym_strobe && (fill_q == FILL_FULL);
    assign combined   = (erri_q >>> 1) + (errq_q >>> 1);
    assign sum        = acc_q + ACC_W'(error_n_q);

    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = '0;
        end else if (in_valid && (fill_q != FILL_FULL)) begin
            fill_d = fill_q + 1'b1;
        end
    end

    always_comb begin
        s1_valid_d  = strobe_eff;
        erri_d      = strobe_eff ? calc_i : erri_q;
        errq_d      = strobe_eff ? calc_q : errq_q;
        err_valid_d = s1_valid_q && !flush;
        error_n_d   = err_valid_d ? combined : error_n_q;
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_avg_d   = err_avg_q;
        avg_valid_d = 1'b0;
        if (flush) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (err_valid_q) begin
            if (cnt_q == CNT_LAST) begin
                err_avg_d   = WIDTH'(sum >>> AVG_LOG2);
                avg_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SPS; k++) begin
                dl_i_q[k] <= '0;
                dl_q_q[k] <= '0;
            end
        end else if (accept) begin
            dl_i_q[0] <= I;
            dl_q_q[0] <= Q;
            for (int k = 1; k < SPS; k++) begin
                dl_i_q[k] <= dl_i_q[k-1];
                dl_q_q[k] <= dl_q_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q      <= '0;
            s1_valid_q  <= 1'b0;
            erri_q      <= '0;
            errq_q      <= '0;
            error_n_q   <= '0;
            err_valid_q <= 1'b0;
            err_avg_q   <= '0;
            avg_valid_q <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            fill_q      <= fill_d;
            s1_valid_q  <= s1_valid_d;
            erri_q      <= erri_d;
            errq_q      <= errq_d;
            error_n_q   <= error_n_d;
            err_valid_q <= err_valid_d;
            err_avg_q   <= err_avg_d;
            avg_valid_q <= avg_valid_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign error_n   = error_n_q;
    assign err_valid = err_valid_q;
    assign err_avg   = err_avg_q;
    assign avg_valid = avg_valid_q;

endmodule

// File: tb/tb_gardner_ted_stream.sv
// Bench for gardner_ted_stream: sign-mode and linear-mode instances share one
// stimulus stream; a sample-level reference model fills expected queues.
module tb_gardner_ted_stream;
  localparam int W   = 16;
  localparam int SPS = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic sym_strobe = 1'b0;
  logic flush = 1'b0;
  logic signed [W-1:0] I = '0;
  logic signed [W-1:0] Q = '0;
  logic signed [W-1:0] error_n, err_avg, lin_error_n, lin_err_avg;
  logic err_valid, avg_valid, lin_err_valid, lin_avg_valid;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] lin_q[$];
  logic [W-1:0] avg_q[$];
  int err_edge_q[$];
  int lin_edge_q[$];
  int avg_edge_q[$];

  int hist_i[$];
  int hist_q[$];
  int fill = 0;
  int acc = 0;
  int cnt = 0;
  int last_err = 0;
  int last_lin = 0;
  int last_avg = 0;

  always #5 clk = ~clk;

  gardner_ted_stream #(.WIDTH(W), .SPS(SPS), .MODE(0), .DIFF_BITS(8), .AVG_LOG2(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .I(I), .Q(Q),
    .sym_strobe(sym_strobe), .flush(flush),
    .error_n(error_n), .err_valid(err_valid), .err_avg(err_avg), .avg_valid(avg_valid)
  );

  gardner_ted_stream #(.WIDTH(W), .SPS(SPS), .MODE(1), .DIFF_BITS(8), .AVG_LOG2(2)) dut_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .I(I), .Q(Q),
    .sym_strobe(sym_strobe), .flush(flush),
    .error_n(lin_error_n), .err_valid(lin_err_valid), .err_avg(lin_err_avg), .avg_valid(lin_avg_valid)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int sign_ref(int c, int m, int p);
    if (c >= 0 && p < 0) return m;
    if (c < 0 && p >= 0) return (m == -32768) ? 32767 : -m;
    return 0;
  endfunction

  function automatic int lin_ref(int c, int m, int p);
    int d;
    int pr;
    d = (c >>> 8) - (p >>> 8);
    pr = (m * d) >>> 7;
    if (pr > 32767) pr = 32767;
    if (pr < -32768) pr = -32768;
    return pr;
  endfunction

  task automatic model_clear_pending();
    exp_q.delete(); lin_q.delete(); avg_q.delete();
    err_edge_q.delete(); lin_edge_q.delete(); avg_edge_q.delete();
  endtask

  task automatic model_flush();
    fill = 0; acc = 0; cnt = 0;
    model_clear_pending();
  endtask

  task automatic model_reset();
    model_flush();
    hist_i.delete(); hist_q.delete();
    last_err = 0; last_lin = 0; last_avg = 0;
  endtask

  task automatic model_accept(input int iv, input int qv, input bit st, input int k);
    int e;
    int le;
    if (st && fill == SPS) begin
      e  = (sign_ref(iv, hist_i[15], hist_i[31]) >>> 1) + (sign_ref(qv, hist_q[15], hist_q[31]) >>> 1);
      le = (lin_ref(iv, hist_i[15], hist_i[31]) >>> 1) + (lin_ref(qv, hist_q[15], hist_q[31]) >>> 1);
      exp_q.push_back(W'(e));  err_edge_q.push_back(k + 1);
      lin_q.push_back(W'(le)); lin_edge_q.push_back(k + 1);
      acc += e;
      cnt++;
      if (cnt == 4) begin
        avg_q.push_back(W'(acc >>> 2));
        avg_edge_q.push_back(k + 2);
        acc = 0;
        cnt = 0;
      end
    end
    hist_i.push_front(iv);
    hist_q.push_front(qv);
    if (hist_i.size() > SPS) begin
      void'(hist_i.pop_back());
      void'(hist_q.pop_back());
    end
    if (fill < SPS) fill++;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit v, input int iv, input int qv, input bit st, input bit fl);
    in_valid = v; I = W'(iv); Q = W'(qv); sym_strobe = st; flush = fl;
    if (!rst) begin
      if (fl) model_flush();
      else if (v) model_accept(iv, qv, st, edge_n + 1);
    end
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  function automatic int filler();
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  function automatic int big_rand();
    return int'($urandom_range(0, 40000)) - 20000;
  endfunction

  task automatic send_sym(input int oi, input int oq, input int mi, input int mq, input bit gaps);
    int f;
    for (int s = 0; s < SPS; s++) begin
      if (gaps && $urandom_range(0, 3) == 0) step(1'b0, filler(), filler(), 1'($urandom_range(0, 1)), 1'b0);
      f = filler();
      if (s == 0) step(1'b1, oi, oq, 1'b1, 1'b0);
      else if (s == 16) step(1'b1, mi, mq, 1'b0, 1'b0);
      else step(1'b1, f, f, 1'b0, 1'b0);
    end
  endtask

  // 32 accepts: #1 is the future prev, #17 the future mid; strobes on #10 and #32 must be ignored.
  task automatic prime(input int ov, input int mv);
    int v;
    for (int a = 1; a <= SPS; a++) begin
      v = (a == 1) ? ov : (a == 17) ? mv : filler();
      step(1'b1, v, v, (a == 10 || a == 32), 1'b0);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (err_valid) begin
        if (exp_q.size() == 0) chk("err_unexp", int'(err_valid), 0);
        else begin
          chk("err_val", int'(error_n), int'($signed(exp_q[0])));
          chk("err_edge", edge_n, err_edge_q[0]);
          last_err = int'($signed(exp_q[0]));
          void'(exp_q.pop_front()); void'(err_edge_q.pop_front());
        end
      end else begin
        chk("err_hold", int'(error_n), last_err);
        if (err_edge_q.size() > 0 && err_edge_q[0] <= edge_n) begin
          chk("err_miss", int'(err_valid), 1);
          void'(exp_q.pop_front()); void'(err_edge_q.pop_front());
        end
      end

      if (lin_err_valid) begin
        if (lin_q.size() == 0) chk("lin_unexp", int'(lin_err_valid), 0);
        else begin
          chk("lin_val", int'(lin_error_n), int'($signed(lin_q[0])));
          chk("lin_edge", edge_n, lin_edge_q[0]);
          last_lin = int'($signed(lin_q[0]));
          void'(lin_q.pop_front()); void'(lin_edge_q.pop_front());
        end
      end else begin
        chk("lin_hold", int'(lin_error_n), last_lin);
        if (lin_edge_q.size() > 0 && lin_edge_q[0] <= edge_n) begin
          chk("lin_miss", int'(lin_err_valid), 1);
          void'(lin_q.pop_front()); void'(lin_edge_q.pop_front());
        end
      end

      if (avg_valid) begin
        if (avg_q.size() == 0) chk("avg_unexp", int'(avg_valid), 0);
        else begin
          chk("avg_val", int'(err_avg), int'($signed(avg_q[0])));
          chk("avg_edge", edge_n, avg_edge_q[0]);
          last_avg = int'($signed(avg_q[0]));
          void'(avg_q.pop_front()); void'(avg_edge_q.pop_front());
        end
      end else begin
        chk("avg_hold", int'(err_avg), last_avg);
        if (avg_edge_q.size() > 0 && avg_edge_q[0] <= edge_n) begin
          chk("avg_miss", int'(avg_valid), 1);
          void'(avg_q.pop_front()); void'(avg_edge_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) step(1'b0, 0, 0, 1'b0, 1'b0);
    chk("rst0_error_n", int'(error_n), 0);
    chk("rst0_err_valid", int'(err_valid), 0);
    chk("rst0_err_avg", int'(err_avg), 0);
    chk("rst0_avg_valid", int'(avg_valid), 0);
    rst = 1'b0;

    // Directed: +500, -500, +500, saturated 32766, no-transition 0, linear 1000 case.
    prime(-8000, 500);
    send_sym(8000, 8000, 500, 500, 1'b0);
    send_sym(-8000, -8000, 500, 500, 1'b0);
    send_sym(8000, 8000, -32768, -32768, 1'b0);
    send_sym(-8000, -8000, 1000, 1000, 1'b0);
    send_sym(-16384, -16384, 1000, 1000, 1'b0);
    send_sym(16384, 16384, 700, 700, 1'b0);
    send_sym(16384, 16384, -700, 300, 1'b0);

    // Random symbols with in_valid gaps and stray unqualified strobes.
    for (int n = 0; n < 8; n++) send_sym(big_rand(), big_rand(), big_rand(), big_rand(), 1'b1);

    // flush with in_valid high mid-group: not counted, accumulator restarts.
    step(1'b1, 1234, 1234, 1'b1, 1'b1);
    prime(-8000, 500);
    send_sym(8000, 8000, 500, 500, 1'b0);
    send_sym(-8000, -3000, 200, -900, 1'b1);
    for (int n = 0; n < 5; n++) send_sym(big_rand(), big_rand(), big_rand(), big_rand(), 1'b1);

    // Asynchronous reset while err_valid is high.
    step(1'b1, 9000, 9000, 1'b1, 1'b0);
    step(1'b1, 5, 5, 1'b0, 1'b0);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("rst1_error_n", int'(error_n), 0);
    chk("rst1_err_valid", int'(err_valid), 0);
    chk("rst1_err_avg", int'(err_avg), 0);
    chk("rst1_avg_valid", int'(avg_valid), 0);
    chk("rst1_lin_error_n", int'(lin_error_n), 0);
    repeat (2) step(1'b1, 77, 77, 1'b1, 1'b0);
    rst = 1'b0;
    prime(16000, -4000);
    for (int n = 0; n < 6; n++) send_sym(big_rand(), big_rand(), big_rand(), big_rand(), 1'b1);

    repeat (6) step(1'b0, 0, 0, 1'b0, 1'b0);
    chk("pending_err", exp_q.size(), 0);
    chk("pending_lin", lin_q.size(), 0);
    chk("pending_avg", avg_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
